// File: rtl/eff_pkg.sv
// Shared definitions for the effect-chain blocks: waveform selector and
// offset-binary <-> two's-complement conversion helpers.
package eff_pkg;

  localparam int unsigned CONV_WIDTH = 32;

  typedef enum logic {
    WAVE_TRI = 1'b0,
    WAVE_SQR = 1'b1
  } wave_e;

  // Offset binary to two's complement: invert the MSB of a w-bit value.
  function automatic logic [CONV_WIDTH-1:0] to_signed(input logic [CONV_WIDTH-1:0] x,
                                                      input int unsigned w);
    return x ^ (CONV_WIDTH'(1) << (w - 1));
  endfunction

  // Two's complement to offset binary: the same MSB inversion.
  function automatic logic [CONV_WIDTH-1:0] to_offset(input logic [CONV_WIDTH-1:0] x,
                                                      input int unsigned w);
    return x ^ (CONV_WIDTH'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/eff_lfo.sv
// Shared LFO: phase accumulator, per-channel phase spread and waveform shaping.
module eff_lfo
  import eff_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned LFO_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           vld_i,
  input  logic [LFO_WIDTH-1:0]           rate_i,
  input  logic                           wave_i,
  input  logic                           spread_i,
  output logic [CHANNELS*GAIN_WIDTH-1:0] w_c
);

  localparam int unsigned OFS_STEP = (1 << LFO_WIDTH) / CHANNELS;
  localparam int unsigned TOP_W    = GAIN_WIDTH + 1;
  localparam int unsigned TOP_SH   = LFO_WIDTH - TOP_W;

  logic [LFO_WIDTH-1:0] p_q;
  logic [TOP_W-1:0]     pc_top [CHANNELS];
  wave_e                wave_sel;

  assign wave_sel = wave_e'(wave_i);

  // Phase advances per accepted sample; cleared while the effect is off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '0;
    end else if (!en) begin
      p_q <= '0;
    end else if (vld_i) begin
      p_q <= p_q + rate_i;
    end
  end

  // Per-channel phase (only MSB + triangle bits kept) and waveform value.
  always_comb begin
    w_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pc_top[c] = TOP_W'((p_q + (spread_i ? LFO_WIDTH'(c * OFS_STEP) : '0)) >> TOP_SH);
      if (wave_sel == WAVE_SQR) begin
        w_c[c*GAIN_WIDTH +: GAIN_WIDTH] = {GAIN_WIDTH{pc_top[c][GAIN_WIDTH]}};
      end else begin
        w_c[c*GAIN_WIDTH +: GAIN_WIDTH] = pc_top[c][GAIN_WIDTH-1:0]
                                          ^ {GAIN_WIDTH{pc_top[c][GAIN_WIDTH]}};
      end
    end
  end

endmodule

// File: rtl/eff_tremolo_mc.sv
// Multi-channel tremolo: LFO-driven gain applied to offset-binary samples,
// two-stage pipeline with a per-sample bypass flag.
module eff_tremolo_mc
  import eff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned LFO_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [LFO_WIDTH-1:0]           rate_i,
  input  logic [GAIN_WIDTH-1:0]          depth_i,
  input  logic                           wave_i,
  input  logic                           spread_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  input  logic                           vld_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic                           vld_o
);

  localparam int unsigned G_W  = GAIN_WIDTH + 1;
  localparam int unsigned DW_W = 2 * GAIN_WIDTH;
  localparam int unsigned P_W  = DATA_WIDTH + GAIN_WIDTH + 2;

  logic [CHANNELS*GAIN_WIDTH-1:0] w_c;
  logic [DW_W-1:0]                dw_prod_c [CHANNELS];
  logic [G_W-1:0]                 g_c       [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   s_c       [CHANNELS];

  logic [G_W-1:0]                 g_q       [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   s_q       [CHANNELS];
  logic                           byp_q;
  logic                           vld1_q;

  logic signed [P_W-1:0]          prod_c    [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   y_c       [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] out_c;

  eff_lfo #(
    .CHANNELS   (CHANNELS),
    .LFO_WIDTH  (LFO_WIDTH),
    .GAIN_WIDTH (GAIN_WIDTH)
  ) u_lfo (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vld_i    (vld_i),
    .rate_i   (rate_i),
    .wave_i   (wave_i),
    .spread_i (spread_i),
    .w_c      (w_c)
  );

  // Gain from depth and waveform; signed view of the incoming samples.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      dw_prod_c[c] = DW_W'(depth_i) * DW_W'(w_c[c*GAIN_WIDTH +: GAIN_WIDTH]);
      g_c[c]       = G_W'(2 ** GAIN_WIDTH) - G_W'(dw_prod_c[c] >> GAIN_WIDTH);
      s_c[c]       = DATA_WIDTH'(to_signed(CONV_WIDTH'(data_i[c*DATA_WIDTH +: DATA_WIDTH]),
                                           DATA_WIDTH));
    end
  end

  // Stage 1: capture gains, signed samples and the bypass flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        g_q[c] <= '0;
        s_q[c] <= '0;
      end
      byp_q  <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= vld_i;
      if (vld_i) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          g_q[c] <= g_c[c];
          s_q[c] <= s_c[c];
        end
        byp_q <= !en;
      end
    end
  end

  // Scale by gain with floor shift, then pick effect or bypass result.
  always_comb begin
    out_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      prod_c[c] = P_W'(s_q[c]) * P_W'($signed({1'b0, g_q[c]}));
      y_c[c]    = DATA_WIDTH'(prod_c[c] >>> GAIN_WIDTH);
      out_c[c*DATA_WIDTH +: DATA_WIDTH] = byp_q
        ? DATA_WIDTH'(to_offset(CONV_WIDTH'(s_q[c]), DATA_WIDTH))
        : DATA_WIDTH'(to_offset(CONV_WIDTH'(y_c[c]), DATA_WIDTH));
    end
  end

  // Stage 2: output register, held between valid samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld1_q;
      if (vld1_q) begin
        data_o <= out_c;
      end
    end
  end

endmodule

// File: doc/eff_tremolo_mc.md
# eff_tremolo_mc

Multi-channel tremolo: amplitude-modulates `CHANNELS` parallel offset-binary audio samples with a shared low-frequency oscillator (LFO). LFO rate, modulation depth and waveform are run-time selectable. An optional phase spread between channels gives auto-pan. It sits in the effect chain between ADC sample capture and the next effect stage, and uses the chain's `data`/`vld` streaming convention.

## Interface
- `DATA_WIDTH`, 12: sample width per channel; unsigned offset binary, midpoint `2**(DATA_WIDTH-1)`.
- `CHANNELS`, 2: number of channels; power of two, at least 1.
- `LFO_WIDTH`, 16: LFO phase accumulator width.
- `GAIN_WIDTH`, 8: depth and waveform resolution. Gain is `GAIN_WIDTH+1` bits.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  1: 1 applies the effect; 0 bypasses it.
- `rate_i`  in  LFO_WIDTH: phase increment per accepted sample.
- `depth_i`  in  GAIN_WIDTH: modulation depth; 0 means no modulation.
- `wave_i`  in  1: 0 selects triangle, 1 selects square.
- `spread_i`  in  1: 1 offsets channel c's phase by `c * 2**LFO_WIDTH / CHANNELS`.
- `data_i`  in  CHANNELS*DATA_WIDTH: input samples; channel 0 in the LSBs.
- `vld_i`  in  1: `data_i` is valid this cycle.
- `data_o`  out  CHANNELS*DATA_WIDTH: processed samples.
- `vld_o`  out  1: `data_o` is valid.

## Operation
- **Phase accumulator `P`:**
  - Each channel's sample is processed against the value of `P` before increment.
  - On each cycle with `vld_i && en`, `P <= P + rate_i`, modulo `2**LFO_WIDTH`; wrap-around is silent.
  - When `en = 0`, `P` is cleared to 0, so the effect always starts at unity gain.
  - When `vld_i = 0`, `P` holds.
- **Per-channel phase:** `Pc = P + (spread_i ? c*2**LFO_WIDTH/CHANNELS : 0)`, modulo `2**LFO_WIDTH`.
- **Waveform value `w` (GAIN_WIDTH bits):**
  - Triangle: take the low `LFO_WIDTH-1` bits of `Pc`, bitwise-invert them if `Pc` MSB = 1, then keep the top `GAIN_WIDTH` bits.
  - Square: `w` = all ones if `Pc` MSB = 1, otherwise 0.
- **Gain:** `g = 2**GAIN_WIDTH - ((depth_i * w) >> GAIN_WIDTH)`.
  - `g` is unsigned, `GAIN_WIDTH+1` bits.
  - Range is `[2, 256]` for the default parameters.
  - `depth_i = 0` gives exactly unity gain.
- **Sample arithmetic:**
  - Convert to signed: `s` = `data_i` with its MSB inverted.
  - `y = (s * g) >>> GAIN_WIDTH`, using an arithmetic shift (truncates toward minus infinity). `y` always fits in `DATA_WIDTH` bits signed, so no saturation is needed.
  - Output: `y` with its MSB inverted.
- **Bypass:** when `en = 0` at acceptance, the output is `data_i` unchanged, with the same latency as the effect path.
- **Mid-stream mode changes:**
  - A per-sample `byp` flag travels with the sample down the pipeline, so in-flight samples complete in the mode they were accepted in.
  - `rate_i`, `depth_i`, `wave_i` and `spread_i` are sampled together with `vld_i`.
- There is no backpressure; downstream always accepts.

## Timing
- Two-stage pipeline; latency 2 cycles from `vld_i` to `vld_o`, with full throughput (one sample per cycle).
  - Stage 1 registers the per-channel gains, the signed samples and `byp`.
  - Stage 2 registers the product-and-shift result into `data_o`.
- `vld_o` is `vld_i` delayed by 2 cycles, regardless of `en`.
- `data_o` holds its last value while `vld_o = 0`.
- **Reset values:** `data_o = 0`, `vld_o = 0`, `P = 0`, and all pipeline valid bits 0.
- Asserting reset mid-stream drops in-flight samples. The first `vld_o` after release occurs 2 cycles after the first `vld_i`.
- When `vld_i` and an `en` falling edge occur in the same cycle, the sample is bypassed and `P` clears.

## Structure
- **Shared package `eff_pkg`** holds:
  - the waveform enum type, with values `WAVE_TRI` and `WAVE_SQR`;
  - `to_signed` / `to_offset` functions (MSB inversion), reused across effects.
- **Sub-module `eff_lfo`** contains the phase accumulator, the per-channel phase offset and the waveform generation. It outputs the `CHANNELS` values of `w`.
- The top level contains the gain computation, the multipliers, the bypass mux and the valid pipeline.

## Test plan
All cases use the default parameters and `CHANNELS = 2`.
- **Reset and bypass:**
  - Hold `rst` low: `data_o = 0`, `vld_o = 0`.
  - Release with `en = 0` and both channels at `0x123`, `vld_i = 1`: `data_o = {0x123, 0x123}` with `vld_o = 1` exactly 2 cycles later.
- **Unity gain:** `en = 1`, `depth_i = 0`, any rate and waveform, data `0x123` → output `0x123` on every sample.
- **Square wave:** `en = 1`, `wave_i = 1`, `depth_i = 0xFF`, `rate_i = 0x4000`, data `0xFFF`:
  - accepted samples 0 and 1 → `0xFFF`;
  - samples 2 and 3 → `0x80F`;
  - the pattern repeats after `P` wraps.
- **Triangle wave:** `wave_i = 0`, `depth_i = 0xFF`, `rate_i = 0x1000`, data `0xFFF`:
  - sample 0 (`P = 0`) → `0xFFF`;
  - sample 4 (`P = 0x4000`, `g = 129`) → `0xC07`;
  - sample 8 (`P = 0x8000`, `g = 2`) → `0x80F`.
- **Spread:** `spread_i = 1`, square wave, `depth_i = 0xFF`, `rate_i = 0`, both channels `0xFFF` → ch0 `0xFFF`, ch1 `0x80F`.
- **Valid gaps and `en` changes:**
  - `vld_i` gaps do not advance `P`, and `vld_o` mirrors the gaps 2 cycles later.
  - Drop `en` with 2 samples in flight: both are processed with the effect; later samples are bypassed; `P` reads 0 afterwards.
  - Assert `rst` mid-stream: `vld_o` drops immediately.
